// File: rtl/div_pkg.sv
// Shared encodings and sizing helpers for the signed sequential divider.
package div_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_FIX  = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        CALC = ST_CALC,
        FIX  = ST_FIX
    } state_t;

    // Iteration counter width for an n-bit divisor / 2n-bit dividend.
    function automatic int unsigned cnt_width(input int unsigned n);
        return $clog2(2 * n) + 1;
    endfunction

endpackage

// File: rtl/div_restore_step.sv
// One radix-2 restoring iteration on magnitudes: shift {rem, dq} left, then
// conditionally subtract the divisor magnitude and record a quotient bit.
module div_restore_step #(
    parameter int unsigned N = 4
) (
    input  logic [N:0]     rem,
    input  logic [2*N-1:0] dq,
    input  logic [N-1:0]   divisor_mag,
    output logic [N:0]     rem_next,
    output logic [2*N-1:0] dq_next
);

    localparam int unsigned RW = N + 2;

    logic [RW-1:0] shifted;
    logic [RW-1:0] diff;
    logic          ge;

    // Compare/subtract at N+2 bits so neither operand is truncated.
    always_comb begin
        shifted  = {rem, dq[2*N-1]};
        diff     = shifted - RW'(divisor_mag);
        ge       = (shifted >= RW'(divisor_mag));
        rem_next = ge ? (N+1)'(diff) : (N+1)'(shifted);
        dq_next  = {dq[2*N-2:0], ge};
    end

endmodule

// File: rtl/signed_seq_divider.sv
// Multi-cycle signed divider (2N-bit dividend / N-bit divisor), truncating
// toward zero, one quotient bit per clock with a start/done handshake.
module signed_seq_divider
    import div_pkg::*;
#(
    parameter int unsigned N = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [2*N-1:0] dividend,
    input  logic [N-1:0]   divisor,
    output logic [N-1:0]   quotient,
    output logic [N-1:0]   remainder,
    output logic           busy,
    output logic           done,
    output logic           ovf,
    output logic           dbz
);

    localparam int unsigned W2 = 2 * N;
    localparam int unsigned CW = cnt_width(N);
    localparam logic [W2-1:0] POS_LIM = W2'((1 << (N - 1)) - 1);
    localparam logic [W2-1:0] NEG_LIM = W2'(1 << (N - 1));
    localparam logic [CW-1:0] LAST    = CW'(W2 - 1);

    state_t        state, state_n;
    logic [W2-1:0] dq, dq_n;
    logic [N:0]    rem, rem_n;
    logic [N-1:0]  dmag, dmag_n;
    logic          sign_q, sign_q_n;
    logic          sign_r, sign_r_n;
    logic          dbz_f, dbz_f_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [N-1:0]  quotient_n, remainder_n;
    logic          busy_n, done_n, ovf_n, dbz_n;

    logic [N:0]    step_rem;
    logic [W2-1:0] step_dq;
    logic          ovf_c;

    div_restore_step #(.N(N)) u_step (
        .rem        (rem),
        .dq         (dq),
        .divisor_mag(dmag),
        .rem_next   (step_rem),
        .dq_next    (step_dq)
    );

    // Quotient magnitude limit depends on the result sign (-2^(N-1) is legal).
    assign ovf_c = sign_q ? (dq > NEG_LIM) : (dq > POS_LIM);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    // Datapath and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dq        <= '0;
            rem       <= '0;
            dmag      <= '0;
            sign_q    <= 1'b0;
            sign_r    <= 1'b0;
            dbz_f     <= 1'b0;
            cnt       <= '0;
            quotient  <= '0;
            remainder <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            ovf       <= 1'b0;
            dbz       <= 1'b0;
        end else begin
            dq        <= dq_n;
            rem       <= rem_n;
            dmag      <= dmag_n;
            sign_q    <= sign_q_n;
            sign_r    <= sign_r_n;
            dbz_f     <= dbz_f_n;
            cnt       <= cnt_n;
            quotient  <= quotient_n;
            remainder <= remainder_n;
            busy      <= busy_n;
            done      <= done_n;
            ovf       <= ovf_n;
            dbz       <= dbz_n;
        end
    end

    // Next-state and next-register logic.
    always_comb begin
        state_n     = state;
        dq_n        = dq;
        rem_n       = rem;
        dmag_n      = dmag;
        sign_q_n    = sign_q;
        sign_r_n    = sign_r;
        dbz_f_n     = dbz_f;
        cnt_n       = cnt;
        quotient_n  = quotient;
        remainder_n = remainder;
        ovf_n       = ovf;
        dbz_n       = dbz;
        done_n      = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    state_n  = CALC;
                    dq_n     = dividend[W2-1] ? W2'(-dividend) : dividend;
                    rem_n    = '0;
                    dmag_n   = divisor[N-1] ? N'(-divisor) : divisor;
                    sign_q_n = dividend[W2-1] ^ divisor[N-1];
                    sign_r_n = dividend[W2-1];
                    dbz_f_n  = (divisor == '0);
                    cnt_n    = '0;
                end
            end
            CALC: begin
                // Zero divisor still iterates the full count for uniform latency.
                rem_n = step_rem;
                dq_n  = step_dq;
                cnt_n = cnt + CW'(1);
                if (cnt == LAST) state_n = FIX;
            end
            FIX: begin
                state_n = IDLE;
                done_n  = 1'b1;
                if (dbz_f) begin
                    quotient_n  = '0;
                    remainder_n = '0;
                    ovf_n       = 1'b0;
                    dbz_n       = 1'b1;
                end else if (ovf_c) begin
                    quotient_n  = '0;
                    remainder_n = '0;
                    ovf_n       = 1'b1;
                    dbz_n       = 1'b0;
                end else begin
                    quotient_n  = sign_q ? N'(-dq[N-1:0]) : dq[N-1:0];
                    remainder_n = sign_r ? N'(-rem[N-1:0]) : rem[N-1:0];
                    ovf_n       = 1'b0;
                    dbz_n       = 1'b0;
                end
            end
            default: state_n = IDLE;
        endcase

        busy_n = (state_n != IDLE);
    end

endmodule

// File: tb/tb_signed_seq_divider.sv
// Self-checking bench for signed_seq_divider (N=4): directed cases, busy
// start rejection, mid-operation reset and back-to-back random divisions.
module tb_signed_seq_divider;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [7:0]   dividend;
    logic [3:0]   divisor;
    logic [3:0]   quotient;
    logic [3:0]   remainder;
    logic         busy, done, ovf, dbz;

    int n_cmp = 0;
    int n_err = 0;

    signed_seq_divider #(.N(N)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .dividend (dividend),
        .divisor  (divisor),
        .quotient (quotient),
        .remainder(remainder),
        .busy     (busy),
        .done     (done),
        .ovf      (ovf),
        .dbz      (dbz)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: Verilog truncating / and % on integers, then range rules.
    function automatic void model(input logic signed [7:0] a, input logic signed [3:0] b,
                                  output logic signed [3:0] q, output logic signed [3:0] r,
                                  output logic o, output logic z);
        int ai, bi, qi, ri;
        ai = a;
        bi = b;
        q = '0; r = '0; o = 1'b0; z = 1'b0;
        if (bi == 0) begin
            z = 1'b1;
        end else begin
            qi = ai / bi;
            ri = ai % bi;
            if (qi > 7 || qi < -8) o = 1'b1;
            else begin
                q = 4'(qi);
                r = 4'(ri);
            end
        end
    endfunction

    // Issue one division from the current cycle (idle or done cycle) and
    // check latency, busy and results. inject_k >= 0 fires a stray start.
    task automatic do_op(input logic signed [7:0] a, input logic signed [3:0] b,
                         input int inject_k, input string tag);
        logic signed [3:0] eq, er;
        logic eo, ez;
        int k;
        bit busy_ok;
        model(a, b, eq, er, eo, ez);
        start = 1'b1; dividend = a; divisor = b;
        @(posedge clk); #1;
        start = 1'b0;
        dividend = 8'($urandom);
        divisor  = 4'($urandom);
        check($sformatf("%s.done_low", tag), done, 0);
        busy_ok = busy;
        k = 0;
        while (k < 30) begin
            if (k == inject_k) begin
                start = 1'b1;
                dividend = 8'sd100;
                divisor  = 4'sd7;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            k++;
            if (done) break;
            if (!busy) busy_ok = 1'b0;
        end
        start = 1'b0;
        check($sformatf("%s.latency", tag), k, 9);
        check($sformatf("%s.busy_run", tag), busy_ok, 1);
        check($sformatf("%s.busy_done", tag), busy, 0);
        check($sformatf("%s.quot", tag), $signed(quotient), eq);
        check($sformatf("%s.rem", tag), $signed(remainder), er);
        check($sformatf("%s.ovf", tag), ovf, eo);
        check($sformatf("%s.dbz", tag), dbz, ez);
    endtask

    initial begin
        logic signed [7:0] ra;
        logic signed [3:0] rb, rc;
        bit seen_done;
        int sel;

        rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset.quot", quotient, 0);
        check("reset.rem", remainder, 0);
        check("reset.busy", busy, 0);
        check("reset.done", done, 0);
        check("reset.ovf", ovf, 0);
        check("reset.dbz", dbz, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        do_op(8'sd3,    4'sd1,  -1, "d3_1");
        do_op(-8'sd42,  4'sd7,  -1, "dm42_7");
        do_op(8'sd10,   -4'sd5, -1, "d10_m5");
        do_op(8'sd43,   -4'sd5, -1, "d43_m5");
        do_op(-8'sd43,  4'sd5,  -1, "dm43_5");
        do_op(8'sd40,   4'sd5,  -1, "ovf40_5");
        do_op(-8'sd128, -4'sd1, -1, "ovfm128_m1");
        do_op(8'sd17,   4'sd0,  -1, "dbz17");
        do_op(8'sd20,   4'sd3,   3, "busy_start");
        do_op(-8'sd43,  4'sd5,  -1, "pre_reset");

        // Abort a division in its fourth cycle.
        start = 1'b1; dividend = 8'sd100; divisor = 4'sd3;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("abort.busy", busy, 0);
        check("abort.done", done, 0);
        check("abort.quot", quotient, 0);
        check("abort.rem", remainder, 0);
        check("abort.ovf", ovf, 0);
        check("abort.dbz", dbz, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        seen_done = 1'b0;
        repeat (12) begin
            @(posedge clk); #1;
            if (done) seen_done = 1'b1;
        end
        check("abort.no_done", seen_done, 0);
        check("abort.idle", busy, 0);
        do_op(8'sd3, 4'sd1, -1, "post_reset");

        // Random back-to-back divisions (each starts on the previous done cycle).
        for (int i = 0; i < 1000; i++) begin
            sel = $urandom_range(0, 2);
            rb = 4'($urandom);
            rc = 4'($urandom);
            case (sel)
                0:       ra = 8'($urandom);
                1:       ra = 8'(int'(rb) * int'(rc));
                default: ra = 8'($signed($urandom_range(0, 40)) - 20);
            endcase
            do_op(ra, rb, -1, $sformatf("rnd%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/signed_seq_divider.md
# signed_seq_divider

Multi-cycle signed divider that inverts the booth multiplier: takes a 2N-bit signed product-width dividend and an N-bit signed divisor, and returns an N-bit signed quotient and remainder. It sits beside the multiplier in the arithmetic datapath and lets a product be checked by dividing it back. The core is radix-2 restoring on operand magnitudes, one quotient bit per clock, with a start/done handshake.

## Interface
- N, default 4: operand width. Divisor, quotient and remainder are N bits; the dividend is 2N bits.
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  request pulse; sampled only in IDLE
- dividend  input  2N  signed dividend; sampled with start
- divisor  input  N  signed divisor; sampled with start
- quotient  output  N  signed quotient; held until the next completion
- remainder  output  N  signed remainder; held until the next completion
- busy  output  1  high from the cycle after start is accepted until done
- done  output  1  one-cycle pulse when the results are valid
- ovf  output  1  quotient not representable in N bits; valid with done and held
- dbz  output  1  divisor was zero; valid with done and held

## Operation
- States:
  - IDLE: start=1 latches the operands and enters CALC.
  - CALC: runs 2N iterations, then moves to FIX.
  - FIX: one cycle that registers the outputs and pulses done, then returns to IDLE.
- Latch step: store |dividend| (2N bits), |divisor| (N bits), sign_q = sign(dividend) XOR sign(divisor), sign_r = sign(dividend), a dbz flag and iteration count 0.
- Each CALC cycle:
  - Shift {rem, dq} left by 1.
  - If rem ≥ |divisor|, subtract |divisor| and set the quotient LSB to 1.
  - rem is N+1 bits wide, so the compare never truncates.
- Result semantics are truncation toward zero, matching Verilog `/` and `%`:
  - The quotient takes sign_q.
  - The remainder takes sign_r.
  - A zero remainder is +0.
- Overflow rules:
  - Quotient magnitude is 2N bits.
  - With sign_q=0, ovf when the magnitude > 2^(N-1)−1.
  - With sign_q=1, ovf when the magnitude > 2^(N-1).
- dbz: when the divisor is 0, CALC still runs the full count so latency stays uniform. In FIX, dbz=1 and ovf=0.
- On ovf or dbz, quotient=0 and remainder=0.
- start while busy is ignored and has no effect on the operation in progress.
- Reset values: every output is 0, the state is IDLE and all internal registers are 0. Asserting rst mid-operation aborts it at once, no done is produced, and the outputs clear to 0.

## Timing
- Call the edge that samples start=1 in IDLE edge 0.
- busy is high after edges 0 through 2N and low after edge 2N+1.
- quotient, remainder, ovf and dbz update at edge 2N+1, and done is high for exactly the cycle after edge 2N+1.
- Latency from start to done is 2N+1 cycles, which is 9 for N=4. Throughput is one division per 2N+2 cycles.
- Back-to-back: start may be asserted in the cycle where done=1. The block is back in IDLE at that point, so that start is accepted.
- Between completions the outputs hold their values. Input changes after edge 0 do not affect the result.

## Structure
- Shared package/include `div_pkg` holds:
  - the state encodings IDLE/CALC/FIX as 2-bit localparams;
  - the count width, $clog2(2N)+1.
- One sub-module, `div_restore_step`: purely combinational, taking (rem, dq, divisor_mag) and returning (rem_next, dq_next). It is instantiated once inside the CALC datapath.
- Magnitude and sign logic stays in the top level.

## Test plan
- dividend=3, divisor=1 → quotient=3, remainder=0, ovf=0, dbz=0, with done exactly 9 cycles after start.
- dividend=−42, divisor=7 → quotient=−6, remainder=0. Also dividend=10, divisor=−5 → quotient=−2, remainder=0. These round-trip the multiplier's products.
- dividend=43, divisor=−5 → quotient=−8 (valid negative limit), remainder=3. Also dividend=−43, divisor=5 → quotient=−8, remainder=−3.
- Overflow and zero divide:
  - dividend=40, divisor=5 → ovf=1, quotient=0, remainder=0.
  - dividend=−128, divisor=−1 → ovf=1.
  - dividend=17, divisor=0 → dbz=1, ovf=0, quotient=0, remainder=0 at the same 9-cycle latency.
- Handshake and reset:
  - A start pulse with new operands while busy is ignored, so the original result is returned.
  - rst asserted at cycle 4 of a division → busy=0, done never pulses, all outputs 0, and the next start completes normally.
- Random self-check: 1000 random (dividend, divisor) pairs compared against the Verilog `/` and `%` reference with the overflow predicate applied, including back-to-back starts issued on the done cycle.
